// File: rtl/tx_pkt_stream.sv
// Transmit packet streamer: drains one buffered packet onto the MAC AXI4-Stream
// port through a 2-entry skid buffer, and gates packet start on received PAUSE.
module tx_pkt_stream #(
   parameter int PKT_LEN    = 1444,
   parameter int ADDR_W     = 13,
   parameter int QUANTA_CYC = 64
) (
   input  logic              tx_fifo_clock,
   input  logic              tx_fifo_resetn,
   input  logic              pkt_ready,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              rd_row_data_done,
   input  logic              rx_frame_pause_req,
   input  logic [15:0]       rx_frame_req_pausetime,
   output logic [7:0]        tx_axis_tdata,
   output logic              tx_axis_tvalid,
   output logic              tx_axis_tlast,
   input  logic              tx_axis_tready
);

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_LOW} state_t;

   localparam logic [ADDR_W-1:0] LEN      = ADDR_W'(PKT_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);
   localparam logic [21:0]       QCYC     = 22'(QUANTA_CYC);

   state_t            state, state_nx;
   logic [21:0]       pause_cnt;
   logic [ADDR_W-1:0] rd_cnt;
   logic [ADDR_W-1:0] tx_cnt;
   logic              dv;
   logic [1:0]        skid_cnt;
   logic [1:0][7:0]   skid;
   logic [1:0]        held_nx;
   logic              start, pop, last_pop, issue;

   // dv marks rd_data carrying last cycle's read; it is presented directly when
   // the skid is empty so byte 0 leaves two cycles after start.
   always_comb begin
      start          = (state == IDLE) & pkt_ready & (pause_cnt == 22'd0) & ~rx_frame_pause_req;
      tx_axis_tvalid = (skid_cnt != 2'd0) | dv;
      tx_axis_tdata  = (skid_cnt != 2'd0) ? skid[0] : (dv ? rd_data : 8'h00);
      tx_axis_tlast  = tx_axis_tvalid & (tx_cnt == LAST_IDX);
      pop            = tx_axis_tvalid & tx_axis_tready;
      last_pop       = pop & tx_axis_tlast;
      held_nx        = skid_cnt + {1'b0, dv} - {1'b0, pop};
      // Stored bytes plus the read about to land never exceed the skid depth.
      issue          = (state == STREAM) & (rd_cnt < LEN) & ((held_nx + {1'b0, rd_en}) < 2'd2);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (start) state_nx = STREAM;
         STREAM:   if (last_pop) state_nx = WAIT_LOW;
         WAIT_LOW: if (!pkt_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge tx_fifo_clock or negedge tx_fifo_resetn) begin
      if (!tx_fifo_resetn) state <= IDLE;
      else                 state <= state_nx;
   end

   always_ff @(posedge tx_fifo_clock or negedge tx_fifo_resetn) begin
      if (!tx_fifo_resetn) begin
         rd_en            <= 1'b0;
         rd_addr          <= '0;
         rd_cnt           <= '0;
         tx_cnt           <= '0;
         dv               <= 1'b0;
         skid_cnt         <= 2'd0;
         skid             <= '0;
         rd_row_data_done <= 1'b0;
      end else begin
         rd_row_data_done <= last_pop;
         dv               <= rd_en;
         skid_cnt         <= held_nx;
         if (start) begin
            rd_en   <= 1'b1;
            rd_addr <= '0;
            rd_cnt  <= ADDR_W'(1);
            tx_cnt  <= '0;
         end else begin
            rd_en <= issue;
            if (issue) begin
               rd_addr <= rd_cnt;
               rd_cnt  <= rd_cnt + 1'b1;
            end
            if (pop) tx_cnt <= tx_cnt + 1'b1;
         end
         if (pop) skid[0] <= (skid_cnt == 2'd2) ? skid[1] : rd_data;
         else if (dv) skid[skid_cnt[0]] <= rd_data;
      end
   end

   always_ff @(posedge tx_fifo_clock or negedge tx_fifo_resetn) begin
      if (!tx_fifo_resetn)         pause_cnt <= 22'd0;
      else if (rx_frame_pause_req) pause_cnt <= {6'd0, rx_frame_req_pausetime} * QCYC;
      else if (pause_cnt != 22'd0) pause_cnt <= pause_cnt - 22'd1;
   end

endmodule

// File: tb/tb_tx_pkt_stream.sv
// Bench for tx_pkt_stream: random buffer contents and tready, with a buffer
// memory model and expectations derived from cycle-level timing rules.
module tb_tx_pkt_stream;
   localparam int PKT_LEN = 1444, ADDR_W = 13, QUANTA_CYC = 64;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              pkt_ready = 1'b0, rd_en, done;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data = 8'h00;
   logic              pz_req = 1'b0;
   logic [15:0]       pz_time = 16'h0;
   logic [7:0]        tdata;
   logic              tvalid, tlast, tready = 1'b1;

   tx_pkt_stream #(.PKT_LEN(PKT_LEN), .ADDR_W(ADDR_W), .QUANTA_CYC(QUANTA_CYC)) dut (
      .tx_fifo_clock(clk), .tx_fifo_resetn(rst_n), .pkt_ready(pkt_ready),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_row_data_done(done),
      .rx_frame_pause_req(pz_req), .rx_frame_req_pausetime(pz_time),
      .tx_axis_tdata(tdata), .tx_axis_tvalid(tvalid), .tx_axis_tlast(tlast),
      .tx_axis_tready(tready));

   always #4 clk = ~clk;

   logic [7:0] mem [PKT_LEN];
   int gcyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int checks = 0, failures = 0;

   // Results of the most recent run_pkt call; cycle 1 is the first cycle after start.
   logic [7:0] got[$];
   int tlast_cnt, tlast_idx, first_en_cyc, first_en_addr, first_v_cyc, last_hs_cyc;
   int done_cyc, done_cnt, bubbles, unstable, max_out, addr_err, timeout, pz_cyc;

   initial begin
      #700000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < PKT_LEN; i++) mem[i] = ramp ? 8'(i) : 8'($urandom_range(0, 255));
   endtask

   function automatic int count_bad();
      int n = (got.size() > PKT_LEN) ? got.size() - PKT_LEN : PKT_LEN - got.size();
      for (int i = 0; i < got.size() && i < PKT_LEN; i++) if (got[i] !== mem[i]) n++;
      return n;
   endfunction

   // Monitor/driver: called at the negedge of the start cycle. Drives tready
   // (mode 1 = random), an optional stall at a byte index and an optional pause
   // request after a byte index; records observations only.
   task automatic run_pkt(input int rmode, input int stall_at, input int stall_len,
                          input int pz_at, input logic [15:0] pz_val);
      int cyc = 0, issued = 0, popped = 0, stall_left = 0;
      bit stall_used = 0, pv = 0, pr = 0, pl = 0;
      logic [7:0] pd = 8'h00;
      got.delete();
      tlast_cnt = 0; tlast_idx = -1; first_en_cyc = -1; first_en_addr = -1; first_v_cyc = -1;
      last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; bubbles = 0; unstable = 0; max_out = 0;
      addr_err = 0; timeout = 0; pz_cyc = -1;
      forever begin
         @(negedge clk); cyc++;
         pz_req = 1'b0;
         if (pv && !pr && (!tvalid || tdata !== pd || tlast !== pl)) unstable++;
         if (rd_en) begin
            issued++;
            if (first_en_cyc < 0) begin first_en_cyc = cyc; first_en_addr = int'(rd_addr); end
            if (int'(rd_addr) >= PKT_LEN) addr_err++;
         end
         if (issued - popped > max_out) max_out = issued - popped;
         if (tvalid && first_v_cyc < 0) first_v_cyc = cyc;
         if (!tvalid && first_v_cyc >= 0 && popped < PKT_LEN) bubbles++;
         if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
         if (popped == stall_at && !stall_used) begin stall_left = stall_len; stall_used = 1; end
         if (stall_left > 0) begin tready = 1'b0; stall_left--; end
         else if (rmode == 1) tready = 1'($urandom_range(0, 1));
         else tready = 1'b1;
         if (tvalid && tready) begin
            got.push_back(tdata);
            if (tlast) begin tlast_cnt++; tlast_idx = popped; end
            popped++; last_hs_cyc = cyc;
            if (popped == pz_at) begin pz_req = 1'b1; pz_time = pz_val; pz_cyc = gcyc; end
         end
         pv = tvalid; pr = tready; pd = tdata; pl = tlast;
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
         if (cyc >= 20000) begin timeout = 1; break; end
      end
      tready = 1'b1;
   endtask

   // Leaves WAIT_LOW (pkt_ready low for one cycle) and raises pkt_ready in IDLE.
   task automatic restart();
      pkt_ready = 1'b0;
      @(negedge clk);
      pkt_ready = 1'b1;
   endtask

   task automatic test_reset();
      pkt_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd_en, rd_addr, done, tdata, tvalid, tlast} !== '0) begin
         failures++; $display("FAIL reset_hold: outputs=%h required 0", {rd_en, rd_addr, done, tdata, tvalid, tlast});
      end
      pkt_ready = 1'b0; rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd_en, rd_addr, done, tdata, tvalid, tlast} !== '0) begin
         failures++; $display("FAIL reset_idle: outputs=%h required 0", {rd_en, rd_addr, done, tdata, tvalid, tlast});
      end
   endtask

   task automatic test_basic();
      int bad;
      fill_mem(1);
      pkt_ready = 1'b1;
      run_pkt(0, -1, 0, -1, 16'h0);
      bad = count_bad();
      checks++; if (timeout != 0) begin failures++; $display("FAIL basic_timeout: no done pulse"); end
      checks++; if (first_en_cyc != 1 || first_en_addr != 0) begin
         failures++; $display("FAIL basic_first_read: cycle %0d addr %0d required cycle 1 addr 0", first_en_cyc, first_en_addr); end
      checks++; if (first_v_cyc != 2) begin failures++; $display("FAIL basic_first_valid: cycle %0d required 2", first_v_cyc); end
      checks++; if (bad != 0) begin failures++; $display("FAIL basic_data: %0d bad bytes of %0d got, required 0", bad, got.size()); end
      checks++; if (got.size() == PKT_LEN && got[PKT_LEN-1] !== 8'hA3) begin
         failures++; $display("FAIL basic_last_byte: %h required a3", got[PKT_LEN-1]); end
      checks++; if (tlast_cnt != 1 || tlast_idx != PKT_LEN - 1) begin
         failures++; $display("FAIL basic_tlast: count %0d index %0d required 1 at %0d", tlast_cnt, tlast_idx, PKT_LEN - 1); end
      checks++; if (last_hs_cyc != 1 + PKT_LEN || bubbles != 0) begin
         failures++; $display("FAIL basic_throughput: last handshake %0d bubbles %0d required %0d and 0", last_hs_cyc, bubbles, 1 + PKT_LEN); end
      checks++; if (done_cyc != 2 + PKT_LEN || done_cnt != 1) begin
         failures++; $display("FAIL basic_done: cycle %0d pulses %0d required cycle %0d one pulse", done_cyc, done_cnt, 2 + PKT_LEN); end
      checks++; if (addr_err != 0) begin failures++; $display("FAIL basic_addr_range: %0d reads past end, required 0", addr_err); end
   endtask

   task automatic test_handshake_guard();
      int extra = 0, bad;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rd_en || tvalid || done) extra++;
      end
      checks++; if (extra != 0) begin failures++; $display("FAIL guard_hold: %0d active cycles with pkt_ready held, required 0", extra); end
      fill_mem(0);
      restart();
      run_pkt(0, -1, 0, -1, 16'h0);
      bad = count_bad();
      checks++; if (first_en_cyc != 1 || bad != 0 || done_cnt != 1) begin
         failures++; $display("FAIL guard_resend: first read %0d bad %0d dones %0d required 1 0 1", first_en_cyc, bad, done_cnt); end
   endtask

   task automatic test_backpressure();
      int bad;
      fill_mem(0);
      restart();
      run_pkt(1, 700, 20, -1, 16'h0);
      bad = count_bad();
      checks++; if (timeout != 0 || bad != 0) begin
         failures++; $display("FAIL bp_data: timeout %0d bad %0d of %0d bytes, required 0 0", timeout, bad, got.size()); end
      checks++; if (tlast_cnt != 1 || tlast_idx != PKT_LEN - 1) begin
         failures++; $display("FAIL bp_tlast: count %0d index %0d required 1 at %0d", tlast_cnt, tlast_idx, PKT_LEN - 1); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", unstable); end
      checks++; if (max_out > 2) begin failures++; $display("FAIL bp_skid_bound: %0d bytes outstanding, required <= 2", max_out); end
      checks++; if (bubbles != 0) begin failures++; $display("FAIL bp_bubbles: %0d, required 0", bubbles); end
      checks++; if (done_cyc != last_hs_cyc + 1 || done_cnt != 1) begin
         failures++; $display("FAIL bp_done: cycle %0d pulses %0d required cycle %0d one pulse", done_cyc, done_cnt, last_hs_cyc + 1); end
   endtask

   task automatic test_pause();
      int pt, hold, early, resume_at;
      for (int t = 0; t < 3; t++) begin
         // t=0: pausetime 3; t=1: random pausetime; t=2: pausetime 3 cancelled at cycle 50
         pt = (t == 1) ? $urandom_range(1, 6) : 3;
         resume_at = (t == 2) ? 50 : -1;
         hold = (t == 2) ? 51 : pt * QUANTA_CYC + 1;
         early = 0;
         fill_mem(0);
         pkt_ready = 1'b0;
         @(negedge clk);
         pz_req = 1'b1; pz_time = 16'(pt);
         for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            pz_req = 1'b0; pkt_ready = 1'b1;
            if (k == resume_at) begin pz_req = 1'b1; pz_time = 16'h0; end
            if (rd_en || tvalid) early++;
         end
         run_pkt(0, -1, 0, -1, 16'h0);
         checks++; if (early != 0 || first_en_cyc != 1 || first_v_cyc != 2) begin
            failures++; $display("FAIL pause_start_%0d: pausetime %0d early %0d first read %0d first valid %0d required 0 1 2",
                                 t, pt, early, first_en_cyc, first_v_cyc); end
         checks++; if (count_bad() != 0 || done_cnt != 1) begin
            failures++; $display("FAIL pause_pkt_%0d: bad %0d dones %0d required 0 1", t, count_bad(), done_cnt); end
      end
   endtask

   task automatic test_pause_mid();
      int extra = 0, seen = -1, dn = 0;
      fill_mem(0);
      restart();
      run_pkt(0, -1, 0, 100, 16'hFFFF);
      checks++; if (count_bad() != 0 || bubbles != 0 || done_cyc != 2 + PKT_LEN) begin
         failures++; $display("FAIL pmid_complete: bad %0d bubbles %0d done %0d required 0 0 %0d", count_bad(), bubbles, done_cyc, 2 + PKT_LEN); end
      restart();
      for (int i = 0; i < 3000; i++) begin @(negedge clk); if (rd_en || tvalid) extra++; end
      checks++; if (extra != 0) begin failures++; $display("FAIL pmid_holdoff: %0d active cycles, required 0", extra); end
      pz_req = 1'b1; pz_time = 16'h0;
      @(negedge clk);
      pz_req = 1'b0;
      fill_mem(0);
      run_pkt(0, -1, 0, -1, 16'h0);
      checks++; if (first_en_cyc != 1 || count_bad() != 0) begin
         failures++; $display("FAIL pmid_resume: first read %0d bad %0d required 1 0", first_en_cyc, count_bad()); end
      // A moderate pause issued mid-packet expires after the packet ends.
      restart();
      run_pkt(0, -1, 0, 100, 16'd40);
      restart();
      for (int i = 0; i < 10000 && seen < 0; i++) begin @(negedge clk); if (rd_en) seen = gcyc; end
      checks++; if (seen != pz_cyc + 40 * QUANTA_CYC + 2) begin
         failures++; $display("FAIL pmid_expiry: first read at %0d required %0d", seen, pz_cyc + 40 * QUANTA_CYC + 2); end
      for (int i = 0; i < 3000 && dn == 0; i++) begin @(negedge clk); if (done) dn = 1; end
      checks++; if (dn != 1) begin failures++; $display("FAIL pmid_drain: done %0d required 1", dn); end
   endtask

   task automatic test_reset_mid();
      int popped = 0, leak = 0;
      fill_mem(0);
      restart();
      for (int i = 0; i < 3000 && popped < 500; i++) begin
         @(negedge clk);
         if (tvalid && tready) popped++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({rd_en, rd_addr, done, tdata, tvalid, tlast} !== '0 || popped != 500) begin
         failures++; $display("FAIL rmid_async: outputs=%h popped %0d required 0 and 500", {rd_en, rd_addr, done, tdata, tvalid, tlast}, popped); end
      repeat (3) begin @(negedge clk); if (done || tlast || tvalid || rd_en) leak++; end
      rst_n = 1'b1;
      run_pkt(0, -1, 0, -1, 16'h0);
      checks++; if (leak != 0 || first_en_cyc != 1 || first_en_addr != 0 || first_v_cyc != 2) begin
         failures++; $display("FAIL rmid_restart: leak %0d first read %0d addr %0d valid %0d required 0 1 0 2",
                              leak, first_en_cyc, first_en_addr, first_v_cyc); end
      checks++; if (count_bad() != 0 || tlast_idx != PKT_LEN - 1 || done_cnt != 1) begin
         failures++; $display("FAIL rmid_packet: bad %0d tlast %0d dones %0d required 0 %0d 1", count_bad(), tlast_idx, done_cnt, PKT_LEN - 1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_handshake_guard();
      test_backpressure();
      test_pause();
      test_pause_mid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tx_pkt_stream.md
# tx_pkt_stream

Transmit-side packet streamer. It drains one complete result/loopback packet from the dual-port packet buffer and emits it byte-serially on the Ethernet MAC AXI4-Stream transmit interface. It honours received PAUSE frames between packets and returns a done strobe to the buffer owner. It runs in the 125 MHz MAC clock domain and is the counterpart of the receive-side packet buffer.

## Interface
Parameters:
- PKT_LEN, 1444: bytes per packet (160*9+4); buffer addresses 0..PKT_LEN-1.
- ADDR_W, 13: buffer address width; must satisfy 2^ADDR_W >= PKT_LEN.
- QUANTA_CYC, 64: clock cycles per pause quantum (512 bit times at 1 Gb/s, 8 bits/cycle).

Ports (clock and reset first):
- tx_fifo_clock  in  1  single clock; all logic on the rising edge.
- tx_fifo_resetn  in  1  asynchronous, active-low reset.
- pkt_ready  in  1  level; buffer holds one complete packet.
- rd_en  out  1  buffer read strobe.
- rd_addr  out  ADDR_W  buffer read address.
- rd_data  in  8  buffer read data, valid exactly 1 cycle after rd_en.
- rd_row_data_done  out  1  one-cycle pulse; packet fully accepted by MAC.
- rx_frame_pause_req  in  1  one-cycle pulse; a PAUSE frame was received.
- rx_frame_req_pausetime  in  16  pause quanta; valid with rx_frame_pause_req.
- tx_axis_tdata  out  8  stream byte.
- tx_axis_tvalid  out  1  stream valid.
- tx_axis_tlast  out  1  last byte of packet.
- tx_axis_tready  in  1  MAC accept.

## Operation
- States: IDLE, STREAM, WAIT_LOW.
- IDLE -> STREAM when pkt_ready=1, pause_cnt=0 and rx_frame_pause_req=0 in the same cycle.
- In STREAM, reads are issued from rd_addr 0 upward into a 2-entry output skid buffer.
  - A read is issued when (skid occupancy + reads in flight) < 2, or when a byte is popped that cycle.
  - No reads are issued past address PKT_LEN-1.
- tx_axis_tdata/tvalid come from the head of the skid buffer.
  - A pop occurs when tvalid & tready.
  - tlast=1 only with byte index PKT_LEN-1.
- On the pop of the tlast byte: rd_row_data_done pulses in the next cycle, and the state moves to WAIT_LOW.
- WAIT_LOW -> IDLE when pkt_ready=0. This prevents re-sending a stale packet.
- Pause counter (22 bits):
  - rx_frame_pause_req loads pause_cnt = rx_frame_req_pausetime * QUANTA_CYC. It loads in any state, and a new request overwrites a running count.
  - pausetime 0 clears the count (resume).
  - Otherwise pause_cnt decrements by 1 per cycle, saturating at 0.
- Pause only blocks packet start. A packet already in STREAM is never interrupted.
- Byte count and address arithmetic are unsigned ADDR_W-bit values; the address never wraps within a packet.

## Timing
- Reset values: rd_en=0, rd_addr=0, rd_row_data_done=0, tx_axis_tdata=0, tx_axis_tvalid=0, tx_axis_tlast=0, pause_cnt=0, state=IDLE, skid empty.
- Start latency, with the start condition true in cycle N:
  - N+1: rd_en=1, rd_addr=0.
  - N+2: tvalid=1 with byte 0.
- With tready held high, one byte is transferred per cycle with no bubbles.
  - Packet occupies cycles N+2 .. N+1+PKT_LEN.
  - rd_row_data_done pulses at N+2+PKT_LEN.
- Backpressure:
  - While tvalid=1 and tready=0, tdata/tlast stay stable and tvalid stays high (AXI rule).
  - The skid buffer never overflows; rd_en stays 0 while it is full.
- After tready rises following a stall, a byte is transferred every cycle with no bubble.
- rx_frame_pause_req in the same cycle as an otherwise-valid start: start is blocked and the count is loaded.
- Asynchronous reset mid-packet:
  - All outputs drop immediately.
  - No tlast and no rd_row_data_done are produced.
  - After release the block re-enters IDLE and resends from address 0 if pkt_ready=1.
- pkt_ready falling during STREAM is ignored; the packet completes.

## Test plan
- Basic packet: pkt_ready=1, tready=1, buffer[i]=i[7:0] -> bytes 0x00,0x01,...,0xA3 (PKT_LEN=1444) on consecutive cycles. tlast only on byte 1443. One rd_row_data_done pulse, 1 cycle after the last handshake.
- Backpressure: tready random at 50%, plus a 20-cycle stall at byte 700 -> exact 1444-byte sequence with no loss or duplication. tdata stable throughout the stall. rd_en=0 while the skid buffer is full.
- Pause: rx_frame_pause_req with pausetime=3 while IDLE, then pkt_ready=1 -> tvalid stays low for 192 cycles, then the start sequence. A second request with pausetime=0 at cycle 50 -> start at cycle 51.
- Pause mid-packet: request with pausetime=0xFFFF at byte 100 -> the packet completes without gaps. The next packet is held off for 4,194,240 cycles.
- Handshake guard: pkt_ready held high after rd_row_data_done -> no second packet until pkt_ready goes low, then high again.
- Reset mid-packet: tx_fifo_resetn=0 at byte 500 -> all outputs 0 asynchronously. After release with pkt_ready=1, byte 0 appears 2 cycles after start with the full 1444-byte packet.
